// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and data access.
// Data has priority, with a bounded data streak so fetch is never starved. One transaction is outstanding at a time.
module mem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_be,
    output logic              d_ack,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              busy
);

    localparam int unsigned BE_W = XLEN / 8;
    localparam int unsigned SW   = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]      state, state_nx;
    logic            owner_d, owner_d_nx;
    logic            drop, drop_nx;
    logic [SW-1:0]   d_streak, d_streak_nx;
    logic            mem_req_nx, mem_we_nx;
    logic [XLEN-1:0] mem_addr_nx, mem_wdata_nx;
    logic [BE_W-1:0] mem_be_nx;
    logic            if_ack_nx, d_ack_nx, busy_nx;
    logic [XLEN-1:0] if_rdata_nx, d_rdata_nx;
    logic            grant_d;
    logic            fetch_flush;

    // Next-state, arbitration and registered-output values
    always_comb begin
        state_nx     = state;
        owner_d_nx   = owner_d;
        drop_nx      = drop;
        d_streak_nx  = d_streak;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        mem_be_nx    = mem_be;
        if_ack_nx    = 1'b0;
        d_ack_nx     = 1'b0;
        if_rdata_nx  = if_rdata;
        d_rdata_nx   = d_rdata;
        grant_d      = d_req && !(if_req && (d_streak == STREAK_MAX));
        fetch_flush  = !owner_d && if_flush;

        case (state)
            S_IDLE: begin
                if (d_req || if_req) begin
                    state_nx   = S_REQ;
                    mem_req_nx = 1'b1;
                    owner_d_nx = grant_d;
                    if (grant_d) begin
                        mem_we_nx    = d_we;
                        mem_addr_nx  = d_addr;
                        mem_wdata_nx = d_we ? d_wdata : '0;
                        mem_be_nx    = d_we ? d_be : '1;
                        // Streak only grows while fetch is actually waiting
                        if (if_req) begin
                            d_streak_nx = (d_streak == STREAK_MAX) ? d_streak : d_streak + SW'(1);
                        end else begin
                            d_streak_nx = '0;
                        end
                    end else begin
                        mem_we_nx    = 1'b0;
                        mem_addr_nx  = if_addr;
                        mem_wdata_nx = '0;
                        mem_be_nx    = '1;
                        d_streak_nx  = '0;
                    end
                end
            end
            S_REQ: begin
                if (fetch_flush) drop_nx = 1'b1;
                if (mem_ready) begin
                    state_nx   = S_WAIT;
                    mem_req_nx = 1'b0;
                end
            end
            S_WAIT: begin
                if (fetch_flush) drop_nx = 1'b1;
                if (mem_rvalid) begin
                    state_nx = S_RESP;
                    if (owner_d) begin
                        d_ack_nx = 1'b1;
                        if (!mem_we) d_rdata_nx = mem_rdata;
                    end else if (!(drop || if_flush)) begin
                        if_ack_nx   = 1'b1;
                        if_rdata_nx = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
                drop_nx  = 1'b0;
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            drop      <= 1'b0;
            d_streak  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            owner_d   <= owner_d_nx;
            drop      <= drop_nx;
            d_streak  <= d_streak_nx;
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            mem_be    <= mem_be_nx;
            if_ack    <= if_ack_nx;
            d_ack     <= d_ack_nx;
            if_rdata  <= if_rdata_nx;
            d_rdata   <= d_rdata_nx;
            busy      <= busy_nx;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between instruction fetch (IF) and the data-memory stage (MEM). It arbitrates the two requesters and holds at most one transaction outstanding. Data has priority, with a bounded-streak fairness guard so fetch is never starved. It returns one-cycle acknowledges that the pipeline hazard logic uses to stall IF or MEM.

## Interface
Parameters:
- XLEN, 32, address/data width
- MAX_D_STREAK, 4, maximum consecutive data grants while fetch waits (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  XLEN  fetch address
- if_flush  in  1  pipeline redirect; cancels delivery of an in-flight fetch
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  XLEN  fetched instruction
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_be  in  XLEN/8  store byte enables
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle (loads)
- d_rdata  out  XLEN  load data
- mem_req  out  1  memory request, held until mem_ready
- mem_we, mem_addr, mem_wdata, mem_be  out  1/XLEN/XLEN/XLEN/8  registered request fields
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response (read data or write completion)
- mem_rdata  in  XLEN  read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states and transitions:
  - IDLE: arbitrates.
  - REQ: mem_req=1. On mem_ready, go to WAIT.
  - WAIT: on mem_rvalid, capture mem_rdata, go to RESP.
  - RESP: ack pulse to owner, then go to IDLE.
- Arbitration is evaluated in IDLE only.
  - d_req alone: grant data. if_req alone: grant fetch.
  - Both asserted: grant data, unless d_streak == MAX_D_STREAK, then grant fetch.
- On grant, register the owner and the request fields into the mem_* registers. They stay stable through REQ.
- d_streak counter (width clog2(MAX_D_STREAK+1)):
  - Increments on a data grant with if_req=1.
  - Clears on any fetch grant, and on a data grant with if_req=0.
  - Saturates at MAX_D_STREAK.
- Stores: mem_we=1, mem_be=d_be. Loads and fetches: mem_we=0, mem_be all ones, mem_wdata=0.
- d_rdata/if_rdata are loaded from the captured response register. They hold their value until the next response for the same owner. Store d_ack still pulses; d_rdata is unchanged.
- Flush handling:
  - if_flush while the fetch owner is in REQ, WAIT or RESP sets a drop flag.
  - The transaction runs to completion on the memory side, but if_ack is suppressed.
  - The drop flag clears on return to IDLE.
  - if_flush in IDLE has no effect.
- mem_rvalid outside WAIT, and mem_ready outside REQ, are ignored.
- Requesters must not change fields while req=1 and ack has not yet been given. Req may deassert the cycle after ack.

## Timing
- Reset values:
  - state IDLE
  - mem_req, mem_we, if_ack, d_ack, busy = 0
  - mem_addr, mem_wdata, mem_be, if_rdata, d_rdata = 0
  - d_streak = 0, drop flag = 0
- Minimum latency, with request sampled in IDLE at cycle 0 and mem_ready=1 / mem_rvalid=1 at the earliest opportunity:
  - mem_req is high in cycle 1.
  - WAIT is cycle 2.
  - ack is in cycle 3.
  - IDLE again in cycle 4.
  - Throughput is 1 transaction per 4 cycles best case.
- Each mem_ready stall cycle adds one cycle in REQ. Each cycle without mem_rvalid adds one cycle in WAIT.
- Acks are registered outputs and high for exactly one cycle. if_ack and d_ack are never high together.
- Reset in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - A stale mem_rvalid arriving afterward is ignored.
- A request arriving in RESP is not granted until the following IDLE cycle.

## Test plan
- Single load: d_req=1, d_we=0, d_addr=0x100, mem_ready and mem_rvalid immediate, mem_rdata=0xDEADBEEF -> mem_req in cycle 1 with mem_addr=0x100; d_ack with d_rdata=0xDEADBEEF in cycle 3; if_ack stays 0.
- Store with backpressure: d_we=1, d_be=0x3, d_wdata=0x1234, mem_ready low for 2 cycles -> mem_req held 3 cycles with fields stable; d_ack one cycle after mem_rvalid; d_rdata unchanged.
- Contention/fairness: if_req and d_req both held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; every fetch is acknowledged.
- Flush: fetch granted, if_flush pulsed during WAIT -> mem transaction completes, if_ack never asserts, FSM returns to IDLE and a subsequent fetch at 0x200 is acknowledged normally.
- Reset mid-op: reset asserted in WAIT, then mem_rvalid=1 in the cycle after reset deasserts -> all outputs at reset values, no ack, busy=0.
- Back-to-back fetches: if_req held with address changing after each ack -> exactly one if_ack per 4 cycles, each carrying the rdata for its own address.
